// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// No logic of its own; pure declarations.
// Not applicable: holds no state and applies no flow control.
package imem_pkg;

   // Default instruction memory depth in 32-bit words.
   localparam int IMEM_SIZE = 1024;

   // Starting value of the running XOR over payload bytes.
   localparam logic [7:0] CSUM_INIT = 8'h00;

   // Number of bytes in the little-endian word-count header.
   localparam int LEN_BYTES = 2;

   // Loader session states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// Latency: word_vld_o pulses the cycle after the lane-3 byte is accepted.
// Backpressure: none; the caller decides when a byte is accepted via acc_i.
module byte_packer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        acc_i,
   input  logic [7:0]  byte_i,
   output logic [1:0]  lane_o,
   output logic [31:0] word_o,
   output logic        word_vld_o
);

   logic [1:0]  lane_q, lane_d;
   logic [31:0] data_q, data_d;
   logic        word_vld_q, word_vld_d;

   // Next-state: shift each new byte in at the top so that after four
   // bytes the first one sits in bits [7:0].
   always_comb begin
      lane_d     = lane_q;
      data_d     = data_q;
      word_vld_d = 1'b0;
      if (clr_i) begin
         lane_d = 2'd0;
         data_d = 32'h0;
      end else if (acc_i) begin
         lane_d     = lane_q + 2'd1;
         data_d     = {byte_i, data_q[31:8]};
         word_vld_d = (lane_q == 2'd3);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lane_q     <= 2'd0;
         data_q     <= 32'h0;
         word_vld_q <= 1'b0;
      end else begin
         lane_q     <= lane_d;
         data_q     <= data_d;
         word_vld_q <= word_vld_d;
      end
   end

   assign lane_o     = lane_q;
   assign word_o     = data_q;
   assign word_vld_o = word_vld_q;

endmodule

// File: rtl/imem_loader.sv
// Framed-byte-stream program loader and instruction-memory port arbiter.
// Latency: o_we one cycle after each lane-3 byte; o_done one cycle after the checksum byte.
// Backpressure: o_byte_ready high only while a frame is being received; stalls are lossless.
module imem_loader
   import imem_pkg::*;
#(
   parameter  int SIZE   = IMEM_SIZE,
   localparam int ADDR_W = $clog2(SIZE)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [7:0]        i_byte,
   input  logic              i_byte_valid,
   output logic              o_byte_ready,
   input  logic [31:0]       i_pc,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_we,
   output logic [31:0]       o_wdata,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_err
);

   localparam int LEN_W = 8 * LEN_BYTES;

   loader_state_t     state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W-1:0] widx_q, widx_d;

   logic              pk_clr;
   logic              pk_acc;
   logic [1:0]        pk_lane;
   logic [31:0]       pk_word;
   logic              pk_vld;

   logic [LEN_W-1:0]  len_full;
   logic              last_byte;
   logic              pc_unused;

   byte_packer u_packer (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .clr_i      (pk_clr),
      .acc_i      (pk_acc),
      .byte_i     (i_byte),
      .lane_o     (pk_lane),
      .word_o     (pk_word),
      .word_vld_o (pk_vld)
   );

   // Full word count as it will look once the high length byte lands.
   assign len_full = {i_byte, len_q[7:0]};

   // The word being assembled is the one at widx_q: the previous word's
   // write (and increment) always completes before the next lane-3 byte.
   assign last_byte = (pk_lane == 2'd3) && ((int'(widx_q) + 1) == int'(len_q));

   // Next-state, datapath updates and outputs for the loader FSM.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      csum_d       = csum_q;
      widx_d       = widx_q;
      pk_clr       = 1'b0;
      pk_acc       = 1'b0;
      o_byte_ready = 1'b0;
      o_cpu_hold   = 1'b1;
      o_done       = 1'b0;
      o_err        = 1'b0;

      // Advance past each written word, saturating so a full-depth load
      // leaves the index on the last word instead of wrapping to zero.
      if (pk_vld && (widx_q != ADDR_W'(SIZE - 1))) begin
         widx_d = widx_q + ADDR_W'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            o_cpu_hold = 1'b0;
            if (i_start) begin
               state_d = ST_LEN_LO;
               len_d   = '0;
               csum_d  = CSUM_INIT;
               widx_d  = '0;
               pk_clr  = 1'b1;
            end
         end
         ST_LEN_LO: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) begin
               len_d[7:0] = i_byte;
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) begin
               len_d = len_full;
               if (int'(len_full) > SIZE) begin
                  state_d = ST_ERR;
               end else if (len_full == '0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) begin
               pk_acc = 1'b1;
               csum_d = csum_q ^ i_byte;
               if (last_byte) begin
                  state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            o_byte_ready = 1'b1;
            if (i_byte_valid) begin
               state_d = (i_byte == csum_q) ? ST_DONE : ST_ERR;
            end
         end
         ST_DONE: begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            o_err = 1'b1;
            if (i_start) begin
               state_d = ST_LEN_LO;
               len_d   = '0;
               csum_d  = CSUM_INIT;
               widx_d  = '0;
               pk_clr  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Loader state registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         csum_q  <= CSUM_INIT;
         widx_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         csum_q  <= csum_d;
         widx_q  <= widx_d;
      end
   end

   // The loader owns the shared address port for the whole session.
   assign o_mem_addr = o_cpu_hold ? widx_q : i_pc[ADDR_W+1:2];
   assign o_we       = pk_vld;
   assign o_wdata    = pk_word;

   // PC bits outside the word-address field are deliberately ignored.
   assign pc_unused  = ^{i_pc[31:ADDR_W+2], i_pc[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed frames, writes captured off-edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Byte stalls are exercised with random valid gaps on one frame.
module tb_imem_loader;

   localparam int SIZE = 1024;
   localparam int AW   = 10;

   logic          i_clk;
   logic          i_rst;
   logic          i_start;
   logic [7:0]    i_byte;
   logic          i_byte_valid;
   logic          o_byte_ready;
   logic [31:0]   i_pc;
   logic [AW-1:0] o_mem_addr;
   logic          o_we;
   logic [31:0]   o_wdata;
   logic          o_cpu_hold;
   logic          o_done;
   logic          o_err;

   int checks;
   int errors;

   // Write/done log, filled only by the monitor below.
   logic [AW-1:0] wq_addr[$];
   logic [31:0]   wq_data[$];
   int            done_cnt;

   // Program payload: two little-endian words; the XOR of all eight bytes is 8'h90.
   logic [7:0]  prog  [8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
   logic [31:0] words [2] = '{32'h0000_0513, 32'h0010_0593};

   imem_loader #(.SIZE(SIZE)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_byte       (i_byte),
      .i_byte_valid (i_byte_valid),
      .o_byte_ready (o_byte_ready),
      .i_pc         (i_pc),
      .o_mem_addr   (o_mem_addr),
      .o_we         (o_we),
      .o_wdata      (o_wdata),
      .o_cpu_hold   (o_cpu_hold),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Record every memory write and done pulse on the falling edge.
   initial done_cnt = 0;
   always @(negedge i_clk) begin
      if (o_we) begin
         wq_addr.push_back(o_mem_addr);
         wq_data.push_back(o_wdata);
      end
      if (o_done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_load();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Offer one byte and return 1 unit after the edge that consumed it.
   task automatic send(input logic [7:0] b, input bit gaps);
      bit got;
      got = 1'b0;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         i_byte_valid = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end
      i_byte       = b;
      i_byte_valid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         got = o_byte_ready;
         tick();
      end
      if (!got) chk("byte_ready_timeout", {31'b0, o_byte_ready}, 32'd1);
   endtask

   // N=2 frame with the given checksum; checks each write one cycle after lane 3.
   task automatic send_n2(input logic [7:0] csum, input bit gaps);
      send(8'h02, gaps);
      send(8'h00, gaps);
      for (int i = 0; i < 8; i++) begin
         send(prog[i], gaps);
         if (i % 4 == 3) begin
            chk("we_after_lane3", {31'b0, o_we}, 32'd1);
            chk("we_addr", {22'b0, o_mem_addr}, i / 4);
            chk("we_data", o_wdata, words[i / 4]);
         end
      end
      send(csum, gaps);
      i_byte_valid = 1'b0;
   endtask

   // Empty frame: N=0 and checksum 8'h00.
   task automatic send_empty();
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      i_byte_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int dbase;
      checks       = 0;
      errors       = 0;
      i_rst        = 1'b1;
      i_start      = 1'b0;
      i_byte       = 8'h00;
      i_byte_valid = 1'b0;
      i_pc         = 32'h0;
      repeat (3) tick();
      i_rst = 1'b0;

      // Reset state and idle address steering.
      chk("rst_hold",  {31'b0, o_cpu_hold},   32'd0);
      chk("rst_ready", {31'b0, o_byte_ready}, 32'd0);
      chk("rst_we",    {31'b0, o_we},         32'd0);
      chk("rst_wdata", o_wdata,               32'd0);
      chk("rst_done",  {31'b0, o_done},       32'd0);
      chk("rst_err",   {31'b0, o_err},        32'd0);
      i_pc = 32'h0000_0010;
      #1 chk("idle_addr_4", {22'b0, o_mem_addr}, 32'd4);
      i_pc = 32'h0000_0FFC;
      #1 chk("idle_addr_1023", {22'b0, o_mem_addr}, 32'd1023);

      // Good N=2 load.
      base  = wq_addr.size();
      dbase = done_cnt;
      start_load();
      chk("start_hold",  {31'b0, o_cpu_hold},   32'd1);
      chk("start_ready", {31'b0, o_byte_ready}, 32'd1);
      chk("start_addr",  {22'b0, o_mem_addr},   32'd0);
      send_n2(8'h90, 1'b0);
      chk("ok_done",      {31'b0, o_done},     32'd1);
      chk("ok_done_hold", {31'b0, o_cpu_hold}, 32'd1);
      tick();
      chk("ok_done_1cyc", {31'b0, o_done},     32'd0);
      chk("ok_hold_drop", {31'b0, o_cpu_hold}, 32'd0);
      chk("ok_pc_addr",   {22'b0, o_mem_addr}, 32'd1023);
      chk("ok_nwrites",   wq_addr.size() - base, 32'd2);
      chk("ok_w0", wq_data[base],     words[0]);
      chk("ok_w1", wq_data[base + 1], words[1]);
      chk("ok_a1", {22'b0, wq_addr[base + 1]}, 32'd1);
      chk("ok_ndone", done_cnt - dbase, 32'd1);

      // Bad checksum: writes still happen, then sticky error.
      base  = wq_addr.size();
      dbase = done_cnt;
      start_load();
      send_n2(8'h00, 1'b0);
      chk("bad_err",   {31'b0, o_err},        32'd1);
      chk("bad_hold",  {31'b0, o_cpu_hold},   32'd1);
      chk("bad_ready", {31'b0, o_byte_ready}, 32'd0);
      repeat (3) tick();
      chk("bad_err_held", {31'b0, o_err}, 32'd1);
      chk("bad_nwrites",  wq_addr.size() - base, 32'd2);
      chk("bad_ndone",    done_cnt - dbase, 32'd0);
      start_load();
      chk("restart_err",   {31'b0, o_err},        32'd0);
      chk("restart_ready", {31'b0, o_byte_ready}, 32'd1);

      // N=0 frame finishes with no writes.
      send_empty();
      chk("n0_done", {31'b0, o_done}, 32'd1);
      tick();
      chk("n0_hold",    {31'b0, o_cpu_hold}, 32'd0);
      chk("n0_nwrites", wq_addr.size() - base, 32'd2);

      // Oversized length: N=1025.
      base = wq_addr.size();
      start_load();
      send(8'h01, 1'b0);
      send(8'h04, 1'b0);
      chk("big_err",   {31'b0, o_err},        32'd1);
      chk("big_ready", {31'b0, o_byte_ready}, 32'd0);
      chk("big_we",    {31'b0, o_we},         32'd0);
      tick();
      i_byte_valid = 1'b0;
      chk("big_err_held", {31'b0, o_err}, 32'd1);
      chk("big_nwrites",  wq_addr.size() - base, 32'd0);
      start_load();
      send_empty();
      tick();

      // Same good frame with random valid gaps.
      base  = wq_addr.size();
      dbase = done_cnt;
      start_load();
      send_n2(8'h90, 1'b1);
      tick();
      chk("gap_nwrites", wq_addr.size() - base, 32'd2);
      chk("gap_w0", wq_data[base],     words[0]);
      chk("gap_w1", wq_data[base + 1], words[1]);
      chk("gap_ndone", done_cnt - dbase, 32'd1);
      chk("gap_hold",  {31'b0, o_cpu_hold}, 32'd0);

      // Reset in the middle of DATA after five payload bytes.
      base  = wq_addr.size();
      dbase = done_cnt;
      start_load();
      send(8'h02, 1'b0);
      send(8'h00, 1'b0);
      for (int i = 0; i < 5; i++) send(prog[i], 1'b0);
      i_byte_valid = 1'b0;
      i_rst        = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("mrst_hold",  {31'b0, o_cpu_hold},   32'd0);
      chk("mrst_ready", {31'b0, o_byte_ready}, 32'd0);
      chk("mrst_we",    {31'b0, o_we},         32'd0);
      chk("mrst_err",   {31'b0, o_err},        32'd0);
      repeat (4) tick();
      chk("mrst_nwrites", wq_addr.size() - base, 32'd1);
      chk("mrst_w0",      wq_data[base], words[0]);
      chk("mrst_ndone",   done_cnt - dbase, 32'd0);

      // Fresh N=1 load after the reset: 78^56^34^12 = 8'h08.
      base = wq_addr.size();
      start_load();
      send(8'h01, 1'b0);
      send(8'h00, 1'b0);
      send(8'h78, 1'b0);
      send(8'h56, 1'b0);
      send(8'h34, 1'b0);
      send(8'h12, 1'b0);
      send(8'h08, 1'b0);
      i_byte_valid = 1'b0;
      chk("post_done", {31'b0, o_done}, 32'd1);
      tick();
      chk("post_nwrites", wq_addr.size() - base, 32'd1);
      chk("post_w0",      wq_data[base], 32'h1234_5678);
      chk("post_a0",      {22'b0, wq_addr[base]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
